// File: rtl/predistort_pkg.sv
// predistort_pkg: settings register offsets and sizing helpers shared by the predistorter.
package predistort_pkg;
    localparam int OFF_WRITE  = 0;
    localparam int OFF_COMMIT = 1;

    function automatic int off_bypass(input int num_channels);
        return 2 * num_channels;
    endfunction

    function automatic int frac_bits(input int width, input int depth);
        return width - depth;
    endfunction

    function automatic int lane_lo(input int c, input int width);
        return c * width;
    endfunction
endpackage

// File: rtl/predistort_lut_bank.sv
// predistort_lut_bank: double-banked gain LUT with one write port and two synchronous read ports.
// Storage is duplicated so each read port (idx, idx+1) owns a plain simple-dual-port RAM.
module predistort_lut_bank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 7
) (
    input  logic             clk,
    input  logic             wen,
    input  logic             wbank,
    input  logic [DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    input  logic             rbank,
    input  logic [DEPTH-1:0] raddr_a,
    input  logic [DEPTH-1:0] raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b
);
    logic [WIDTH-1:0] mem_a [2**(DEPTH+1)];
    logic [WIDTH-1:0] mem_b [2**(DEPTH+1)];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem_a[{wbank, waddr}] <= wdata;
            mem_b[{wbank, waddr}] <= wdata;
        end
        if (ren) begin
            rdata_a <= mem_a[{rbank, raddr_a}];
            rdata_b <= mem_b[{rbank, raddr_b}];
        end
    end
endmodule

// File: rtl/predistort_lut_mc.sv
// predistort_lut_mc: multi-lane LUT magnitude predistorter, linear interpolation, packet-boundary bank swap.
// Define PREDISTORT_LUT_MC_BYPASS_EN to add the per-channel bypass register.
module predistort_lut_mc
    import predistort_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 7,
    parameter int SR_BASE      = 129
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          set_stb,
    input  logic [7:0]                    set_addr,
    input  logic [31:0]                   set_data,
    input  logic [NUM_CHANNELS*WIDTH-1:0] i_tdata,
    input  logic                          i_tlast,
    input  logic                          i_tvalid,
    output logic                          i_tready,
    output logic [NUM_CHANNELS*WIDTH-1:0] o_tdata,
    output logic                          o_tlast,
    output logic                          o_tvalid,
    input  logic                          o_tready,
    output logic [NUM_CHANNELS-1:0]       active_bank,
    output logic [NUM_CHANNELS-1:0]       load_overflow
);
    localparam int F = frac_bits(WIDTH, DEPTH);

    logic v1, v2, v3, last1, last2, last3, sop, en, accept;
    logic unused_set_data;

    assign unused_set_data = ^set_data;
    assign en       = o_tready || !v3;
    assign i_tready = en;
    assign accept   = i_tvalid && en;
    assign o_tvalid = v3;
    assign o_tlast  = last3;

    always_ff @(posedge clk) begin
        if (reset) begin
            {v1, v2, v3, last1, last2, last3} <= '0;
            sop <= 1'b1;
        end else begin
            if (en) begin
                v1    <= i_tvalid;
                v2    <= v1;
                v3    <= v2;
                last1 <= i_tvalid && i_tlast;
                last2 <= last1;
                last3 <= last2;
            end
            if (accept) sop <= i_tlast;
        end
    end

`ifdef PREDISTORT_LUT_MC_BYPASS_EN
    logic [NUM_CHANNELS-1:0] bypass;

    always_ff @(posedge clk) begin
        if (reset) bypass <= '1;
        else if (set_stb && set_addr == 8'(SR_BASE + off_bypass(NUM_CHANNELS))) bypass <= set_data[NUM_CHANNELS-1:0];
    end
`endif

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic                      wr_hit, commit_hit, swap, bank, pending, overflow;
        logic [DEPTH-1:0]          wptr, idx, idx_next;
        logic [WIDTH-1:0]          x, base, next, base2, corr2, y;
        logic [F-1:0]              frac1;
        logic signed [WIDTH:0]     diff;
        logic signed [WIDTH+F+1:0] prod;
`ifdef PREDISTORT_LUT_MC_BYPASS_EN
        logic [WIDTH-1:0] x1, x2;
        logic             byp1, byp2;
`endif

        assign x          = i_tdata[lane_lo(c, WIDTH) +: WIDTH];
        assign idx        = x[WIDTH-1 -: DEPTH];
        assign idx_next   = (&idx) ? idx : idx + 1'b1;
        assign wr_hit     = set_stb && set_addr == 8'(SR_BASE + 2*c + OFF_WRITE);
        assign commit_hit = set_stb && set_addr == 8'(SR_BASE + 2*c + OFF_COMMIT);
        // Any write to this channel defers the swap so the packet stays on one table.
        assign swap       = pending && sop && accept && !(wr_hit || commit_hit);

        always_ff @(posedge clk) begin
            if (reset) begin
                bank     <= 1'b0;
                pending  <= 1'b0;
                wptr     <= '0;
                overflow <= 1'b0;
            end else begin
                if (swap) begin
                    bank    <= !bank;
                    pending <= 1'b0;
                end
                if (wr_hit) begin
                    wptr <= wptr + 1'b1;
                    if (&wptr) overflow <= 1'b1;
                end
                if (commit_hit) begin
                    pending  <= 1'b1;
                    wptr     <= '0;
                    overflow <= 1'b0;
                end
            end
        end

        predistort_lut_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank (
            .clk(clk),
            .wen(wr_hit || commit_hit),
            .wbank(!bank),
            .waddr(wptr),
            .wdata(set_data[WIDTH-1:0]),
            .ren(en),
            .rbank(bank ^ swap),
            .raddr_a(idx),
            .raddr_b(idx_next),
            .rdata_a(base),
            .rdata_b(next)
        );

        assign diff = $signed({1'b0, next}) - $signed({1'b0, base});
        assign prod = (WIDTH+F+2)'(diff) * (WIDTH+F+2)'($signed({1'b0, frac1}));

        always_ff @(posedge clk) begin
            if (en) begin
                frac1 <= x[F-1:0];
`ifdef PREDISTORT_LUT_MC_BYPASS_EN
                x1    <= x;
                byp1  <= bypass[c];
`endif
            end
            if (en && v1) begin
                base2 <= base;
                corr2 <= WIDTH'(prod >>> F);
`ifdef PREDISTORT_LUT_MC_BYPASS_EN
                x2    <= x1;
                byp2  <= byp1;
`endif
            end
        end

        always_ff @(posedge clk) begin
            if (reset) y <= '0;
`ifdef PREDISTORT_LUT_MC_BYPASS_EN
            else if (en && v2) y <= byp2 ? x2 : base2 + corr2;
`else
            else if (en && v2) y <= base2 + corr2;
`endif
        end

        assign o_tdata[lane_lo(c, WIDTH) +: WIDTH] = y;
        assign active_bank[c]   = bank;
        assign load_overflow[c] = overflow;
    end
endmodule

// File: doc/predistort_lut_mc.md
Name: predistort_lut_mc

Overview:
Multi-channel magnitude predistorter. Each lane maps an unsigned magnitude through a per-channel 2^DEPTH-entry gain LUT, with linear interpolation between adjacent entries. Tables are loaded from the settings bus into a shadow bank and swap in atomically at the next packet boundary. It sits between the CHDR deframer / stream splitter and the per-channel CHDR framers inside a NoC block, and replaces the single-lane, fixed-table predistorter.

Parameters:
- NUM_CHANNELS, 4, number of lockstep lanes (1..8).
- WIDTH, 16, sample and LUT entry width (unsigned).
- DEPTH, 7, log2 of LUT entries per bank; requires DEPTH < WIDTH.
- SR_BASE, 129, first settings address used by the block.

Ports:
- clk  in  1  block clock (ce_clk domain).
- reset  in  1  synchronous, active-high.
- set_stb  in  1  settings write strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- i_tdata  in  NUM_CHANNELS*WIDTH  magnitudes; lane c at [c*WIDTH +: WIDTH].
- i_tlast  in  1  end of packet, shared by all lanes.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  NUM_CHANNELS*WIDTH  predistorted magnitudes, same lane packing.
- o_tlast  out  1  end of packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- active_bank  out  NUM_CHANNELS  current read bank per channel.
- load_overflow  out  NUM_CHANNELS  sticky flag: write pointer wrapped before commit.

Behaviour:
- Settings map, per channel c:
  - SR_BASE+2c: write set_data[WIDTH-1:0] to shadow[c][wptr[c]], then wptr[c] increments.
  - SR_BASE+2c+1: same write, then pending[c]=1 and wptr[c]=0 (commit).
  - The shadow bank is ~active_bank[c].
- wptr wraps from 2^DEPTH-1 to 0. A wrap by a non-commit write sets load_overflow[c]. A commit clears load_overflow[c].
- sop register: 1 after reset; cleared when a beat is accepted; set again when a tlast beat is accepted.
- Swap rule for channel c: in a cycle with pending[c] && sop && i_tvalid && i_tready:
  - active_bank[c] toggles and pending[c] clears;
  - the accepted beat uses the new bank.
- Swap is suppressed in any cycle with a settings write to channel c's registers. It then waits for the next packet start, so the current packet stays on the old table.
- Writes while pending[c]=1 go to the still-inactive shadow bank. This is legal and overwrites it.
- Arithmetic per lane:
  - idx = x[WIDTH-1 -: DEPTH]; frac = x[WIDTH-DEPTH-1:0]; F = WIDTH-DEPTH.
  - y = L[idx] + (((L[idx+1] - L[idx]) * frac) >>> F), with signed difference of WIDTH+1 bits and arithmetic shift.
  - When idx = 2^DEPTH-1: y = L[idx], with no interpolation and no read wrap.
  - The result always lies between the two entries, so there is no saturation.
- Pipeline: 3-stage, latency 3 cycles, 1 beat/cycle throughput.
  - S1: synchronous dual LUT read (idx and idx+1), capture frac.
  - S2: difference and multiply.
  - S3: add and register output.
  - Global advance en = o_tready || !v3; i_tready = en. Valid bits v1..v3 and tlast travel with the data.
  - With en=0, all stages including the RAM read outputs hold.
- Reset values:
  - v1..v3 = 0, o_tvalid = 0, o_tdata = 0, o_tlast = 0.
  - active_bank = 0, pending = 0, wptr = 0, load_overflow = 0, sop = 1.
  - LUT contents are not reset.
- Reset mid-packet: in-flight beats are discarded and the next accepted beat is treated as start of packet. A partially loaded table is abandoned, since wptr is 0 and pending is 0.
- o_tdata/o_tlast are stable while o_tvalid && !o_tready.

Optional Feature:
- Macro: PREDISTORT_LUT_MC_BYPASS_EN.
- Defined:
  - Adds register SR_BASE+2*NUM_CHANNELS; bit c sets bypass for channel c. Reset value is all ones, so unloaded tables pass through.
  - A bypassed lane outputs x unchanged with the same 3-cycle latency.
  - The bypass bit is sampled in S1 with the beat.
- Not defined: no register and no bypass logic; every lane always goes through its LUT.

Decomposition:
- Package predistort_pkg:
  - register offsets: OFF_WRITE=0, OFF_COMMIT=1, OFF_BYPASS=2*NUM_CHANNELS;
  - the F = WIDTH-DEPTH helper;
  - lane slice helper.
- Sub-module predistort_lut_bank, instantiated per channel:
  - two banks of 2^DEPTH x WIDTH storage, one write port (bank, addr, data);
  - two synchronous read ports (idx, idx+1) with read-enable;
  - implemented as duplicated RAMs.
- The top level holds the settings decode, bank/pending/sop control and the arithmetic pipeline.

Test Plan:
- Identity: load L[i]=i*512 on all channels (WIDTH 16, DEPTH 7), commit, send 0x1234 -> 0x1234 on every lane, exactly 3 cycles after acceptance.
- Interpolation and top edge: L[2]=1000, L[3]=2000, L[127]=0xFE00, input 0x0500 -> 1500; input 0xFFFF -> 0xFE00.
- Bank swap at boundary: table A active; load table B (L[i]=i*256) and commit during beat 2 of a 4-beat packet:
  - remaining beats use A;
  - beat 0 of the next packet uses B (0x0400 -> 0x0200);
  - active_bank toggles once.
- Swap suppression: settings write to channel 1 in the same cycle as the next packet's first beat -> channel 1 keeps the old table for the whole packet, swaps on the following packet; other channels swap normally.
- Backpressure: random o_tready (50%) over 200 beats -> no loss or duplication, o_tdata held during stalls, tlast aligned.
- Reset and overflow: 130 non-commit writes -> load_overflow[c]=1; reset mid-packet -> o_tvalid=0 next cycle, pending=0, active_bank=0, load_overflow=0.
